// File: rtl/vending_machine_multi_if.sv
// Coin-acceptor / dispenser-side signal bundle for the multi-item vending controller.
// The master drives coins and requests; the slave (controller) drives vend, change and status.
interface vending_machine_multi_if #(
   parameter int N_ITEMS  = 4,
   parameter int CREDIT_W = 8
);
   localparam int SEL_W = $clog2(N_ITEMS);

   logic                n;
   logic                d;
   logic                q;
   logic [SEL_W-1:0]    sel;
   logic                buy;
   logic                cancel;
   logic                restock;
   logic                vend;
   logic [SEL_W-1:0]    vend_item;
   logic                chg_d;
   logic                chg_n;
   logic                coin_reject;
   logic                busy;
   logic [CREDIT_W-1:0] credit;
   logic [N_ITEMS-1:0]  sold_out;

   modport master (
      output n, d, q, sel, buy, cancel, restock,
      input  vend, vend_item, chg_d, chg_n, coin_reject, busy, credit, sold_out
   );

   modport slave (
      input  n, d, q, sel, buy, cancel, restock,
      output vend, vend_item, chg_d, chg_n, coin_reject, busy, credit, sold_out
   );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: credit in 5-cent units, per-item price and stock,
// one-coin-per-cycle change/refund. rs_i is the asynchronous active-low reset.
//
// state   | meaning
// COLLECT | accepting coins, buy and cancel requests
// VEND    | one-cycle dispense pulse for the latched item
// CHANGE  | paying out remaining credit, one dime or nickel per cycle
module vending_machine_multi #(
   parameter int                          N_ITEMS    = 4,
   parameter int                          CREDIT_W   = 8,
   parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {8'd8, 8'd6, 8'd5, 8'd4},
   parameter int                          MAX_CREDIT = 40,
   parameter int                          STOCK_W    = 4,
   parameter int                          STOCK_INIT = 8
) (
   input logic                    clk_i,
   input logic                    rs_i,
   vending_machine_multi_if.slave bus
);
   localparam int SEL_W = $clog2(N_ITEMS);

   typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [STOCK_W-1:0]  stock_q [N_ITEMS];
   logic [STOCK_W-1:0]  stock_d [N_ITEMS];
   logic [SEL_W-1:0]    item_q, item_d;
   logic                rej_q, rej_d;

   logic [CREDIT_W-1:0] price;
   logic [CREDIT_W:0]   coin_val;
   logic [CREDIT_W:0]   coin_sum;
   logic                sel_ok, coin_any, coin_multi, cancel_ok, buy_ok;

   always_comb begin
      sel_ok     = int'(bus.sel) < N_ITEMS;
      price      = sel_ok ? PRICES[int'(bus.sel)*CREDIT_W +: CREDIT_W] : '1;
      coin_any   = bus.n | bus.d | bus.q;
      coin_multi = (bus.n & bus.d) | (bus.n & bus.q) | (bus.d & bus.q);
      coin_val   = bus.n ? (CREDIT_W+1)'(1) : (bus.d ? (CREDIT_W+1)'(2) : (CREDIT_W+1)'(5));
      coin_sum   = {1'b0, credit_q} + coin_val;
      cancel_ok  = (state_q == COLLECT) && bus.cancel && (credit_q != '0);
      buy_ok     = (state_q == COLLECT) && !cancel_ok && bus.buy && sel_ok &&
                   (stock_q[bus.sel] != '0) && (credit_q >= price);
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      stock_d  = stock_q;
      item_d   = item_q;
      rej_d    = 1'b0;
      case (state_q)
         COLLECT: begin
            if (cancel_ok) begin
               state_d = CHANGE;
            end else if (buy_ok) begin
               credit_d          = credit_q - price;
               stock_d[bus.sel]  = stock_q[bus.sel] - STOCK_W'(1);
               item_d            = bus.sel;
               state_d           = VEND;
            end
            // a coin only lands when no request was accepted and the ceiling holds
            if (coin_any) begin
               if (cancel_ok || buy_ok || (coin_sum > (CREDIT_W+1)'(MAX_CREDIT)))
                  rej_d = 1'b1;
               else
                  credit_d = coin_sum[CREDIT_W-1:0];
            end
            if (coin_multi)
               rej_d = 1'b1;
         end
         VEND: begin
            rej_d   = coin_any;
            state_d = (credit_q != '0) ? CHANGE : COLLECT;
         end
         CHANGE: begin
            rej_d    = coin_any;
            credit_d = (credit_q >= CREDIT_W'(2)) ? credit_q - CREDIT_W'(2) : '0;
            if (credit_q <= CREDIT_W'(2))
               state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
      if (bus.restock) begin
         for (int i = 0; i < N_ITEMS; i++)
            stock_d[i] = STOCK_W'(STOCK_INIT);
      end
   end

   always_ff @(posedge clk_i or negedge rs_i) begin
      if (!rs_i) begin
         state_q  <= COLLECT;
         credit_q <= '0;
         item_q   <= '0;
         rej_q    <= 1'b0;
         for (int i = 0; i < N_ITEMS; i++)
            stock_q[i] <= STOCK_W'(STOCK_INIT);
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         item_q   <= item_d;
         rej_q    <= rej_d;
         stock_q  <= stock_d;
      end
   end

   assign bus.vend        = (state_q == VEND);
   assign bus.vend_item   = (state_q == VEND) ? item_q : '0;
   assign bus.chg_d       = (state_q == CHANGE) && (credit_q >= CREDIT_W'(2));
   assign bus.chg_n       = (state_q == CHANGE) && (credit_q == CREDIT_W'(1));
   assign bus.busy        = (state_q != COLLECT);
   assign bus.coin_reject = rej_q;
   assign bus.credit      = credit_q;

   always_comb begin
      for (int i = 0; i < N_ITEMS; i++)
         bus.sold_out[i] = (stock_q[i] == '0);
   end
endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: random traffic against a payout-plan reference model,
// then a table of directed vectors and hand sequences for ceiling, sold-out and reset cases.
module tb_vending_machine_multi;
   logic clk = 1'b0;
   logic rs  = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   vending_machine_multi_if #(.N_ITEMS(4), .CREDIT_W(8)) vif ();

   vending_machine_multi dut (
      .clk_i (clk),
      .rs_i  (rs),
      .bus   (vif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [18:0] act_all();
      return {vif.vend, vif.vend_item, vif.chg_d, vif.chg_n, vif.coin_reject, vif.busy,
              vif.credit, vif.sold_out};
   endfunction

   task automatic drive(input logic [2:0] c, input logic [1:0] s, input logic b,
                        input logic cn, input logic r);
      vif.n = c[2]; vif.d = c[1]; vif.q = c[0];
      vif.sel = s; vif.buy = b; vif.cancel = cn; vif.restock = r;
   endtask

   // one clock of directed stimulus; outputs are sampled 1 time unit after the edge
   task automatic step(input logic [2:0] c, input logic [1:0] s, input logic b,
                       input logic cn, input logic r);
      @(negedge clk);
      drive(c, s, b, cn, r);
      @(posedge clk);
      #1;
      drive(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- reference model: credit, stock and a queue of busy-cycle outputs
   typedef struct {
      bit v;
      int item;
      bit cd;
      bit cn;
      int cr;
   } ev_t;

   ev_t plan[$];
   int  m_credit;
   int  m_stock[4];
   bit  m_rej;
   int  price_tab[4];

   function automatic void push_change(input int c);
      ev_t e;
      while (c > 0) begin
         e.v = 0; e.item = 0; e.cr = c;
         e.cd = (c >= 2); e.cn = (c == 1);
         plan.push_back(e);
         c -= e.cd ? 2 : 1;
      end
   endfunction

   function automatic void model_reset();
      plan.delete();
      m_credit = 0;
      m_rej = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = 8;
   endfunction

   function automatic void model_step(input bit cn_, input bit cd_, input bit cq_, input int s,
                                      input bit b, input bit cancel, input bit r);
      int  ncoin = int'(cn_) + int'(cd_) + int'(cq_);
      int  v;
      bit  acted = 0;
      bit  rej = 0;
      ev_t e;
      if (plan.size() > 0) begin
         void'(plan.pop_front());
         rej = (ncoin > 0);
      end else begin
         if (cancel && m_credit > 0) begin
            push_change(m_credit);
            m_credit = 0;
            acted = 1;
         end else if (b && m_stock[s] > 0 && m_credit >= price_tab[s]) begin
            m_credit -= price_tab[s];
            m_stock[s]--;
            e.v = 1; e.item = s; e.cd = 0; e.cn = 0; e.cr = m_credit;
            plan.push_back(e);
            push_change(m_credit);
            m_credit = 0;
            acted = 1;
         end
         if (ncoin > 1) rej = 1;
         if (ncoin > 0) begin
            v = cn_ ? 1 : (cd_ ? 2 : 5);
            if (acted || m_credit + v > 40) rej = 1;
            else m_credit += v;
         end
      end
      if (r) for (int i = 0; i < 4; i++) m_stock[i] = 8;
      m_rej = rej;
   endfunction

   function automatic logic [18:0] model_view();
      logic [3:0] so;
      for (int i = 0; i < 4; i++) so[i] = (m_stock[i] == 0);
      if (plan.size() > 0)
         return {plan[0].v, plan[0].v ? 2'(plan[0].item) : 2'd0, plan[0].cd, plan[0].cn,
                 m_rej, 1'b1, 8'(plan[0].cr), so};
      return {1'b0, 2'd0, 1'b0, 1'b0, m_rej, 1'b0, 8'(m_credit), so};
   endfunction

   // ---------------- directed vector table
   typedef struct packed {
      logic [2:0] coins;
      logic [1:0] sel;
      logic       buy;
      logic       cancel;
      logic [7:0] credit;
      logic       vend;
      logic [1:0] item;
      logic       cd;
      logic       cn;
      logic       rej;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [2:0] c, input logic [1:0] s, input logic b,
                               input logic cn, input int cr, input logic v, input logic [1:0] it,
                               input logic xd, input logic xn, input logic rj, input logic bz);
      vec_t t;
      t.coins = c; t.sel = s; t.buy = b; t.cancel = cn; t.credit = 8'(cr);
      t.vend = v; t.item = it; t.cd = xd; t.cn = xn; t.rej = rj; t.busy = bz;
      return t;
   endfunction

   task automatic reset_dut();
      drive(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
      rs = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(act_all()), 32'(19'd0));
      @(negedge clk);
      rs = 1'b1;
      model_reset();
   endtask

   logic       rn, rd, rq, rb, rc, rr;
   logic [1:0] rsel;
   int         dimes, nickels, vends;

   initial begin
      price_tab[0] = 4; price_tab[1] = 5; price_tab[2] = 6; price_tab[3] = 8;
      model_reset();
      reset_dut();

      // random traffic against the reference model
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         chk("random", 32'(act_all()), 32'(model_view()));
         rn = ($urandom_range(0, 9) == 0);
         rd = ($urandom_range(0, 9) == 0);
         rq = ($urandom_range(0, 7) == 0);
         rb = ($urandom_range(0, 4) == 0);
         rc = ($urandom_range(0, 29) == 0);
         rr = ($urandom_range(0, 199) == 0);
         rsel = 2'($urandom_range(0, 3));
         drive({rn, rd, rq}, rsel, rb, rc, rr);
         model_step(rn, rd, rq, int'(rsel), rb, rc, rr);
      end
      reset_dut();

      // sale with nickel change, sale with dime change, rejected buy + refund, ceiling
      vecs.push_back(mk(3'b100, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b010, 2'd0, 0, 0, 3, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b010, 2'd0, 0, 0, 5, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b000, 2'd0, 1, 0, 1, 1, 2'd0, 0, 0, 0, 1));
      vecs.push_back(mk(3'b000, 2'd0, 0, 0, 1, 0, 2'd0, 0, 1, 0, 1));
      vecs.push_back(mk(3'b000, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b001, 2'd0, 0, 0, 5, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b001, 2'd0, 0, 0, 10, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b000, 2'd3, 1, 0, 2, 1, 2'd3, 0, 0, 0, 1));
      vecs.push_back(mk(3'b000, 2'd0, 0, 0, 2, 0, 2'd0, 1, 0, 0, 1));
      vecs.push_back(mk(3'b000, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b100, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b010, 2'd0, 0, 0, 3, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b000, 2'd1, 1, 0, 3, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b000, 2'd0, 0, 1, 3, 0, 2'd0, 1, 0, 0, 1));
      vecs.push_back(mk(3'b000, 2'd0, 0, 0, 1, 0, 2'd0, 0, 1, 0, 1));
      vecs.push_back(mk(3'b000, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
      for (int i = 1; i <= 8; i++)
         vecs.push_back(mk(3'b001, 2'd0, 0, 0, 5 * i, 0, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(3'b100, 2'd0, 0, 0, 40, 0, 2'd0, 0, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].coins, vecs[i].sel, vecs[i].buy, vecs[i].cancel, 1'b0);
         chk($sformatf("vec%0d", i),
             32'({vif.credit, vif.vend, vif.vend_item, vif.chg_d, vif.chg_n,
                  vif.coin_reject, vif.busy}),
             32'({vecs[i].credit, vecs[i].vend, vecs[i].item, vecs[i].cd, vecs[i].cn,
                  vecs[i].rej, vecs[i].busy}));
      end

      // refund of a full 40 units: twenty dimes, no dead cycle, then double coin at zero
      step(3'b000, 2'd0, 1'b0, 1'b1, 1'b0);
      dimes = 0; nickels = 0;
      for (int k = 0; k < 30 && vif.busy; k++) begin
         dimes += int'(vif.chg_d);
         nickels += int'(vif.chg_n);
         step(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
      end
      chk("refund40_dimes", 32'(dimes), 32'd20);
      chk("refund40_nickels", 32'(nickels), 32'd0);
      chk("refund40_idle", 32'({vif.busy, vif.credit}), 32'({1'b0, 8'd0}));
      step(3'b101, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("n_plus_q", 32'({vif.credit, vif.coin_reject}), 32'({8'd1, 1'b1}));
      step(3'b000, 2'd0, 1'b0, 1'b1, 1'b0);
      step(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);

      // exhaust item 2, check sold-out gating and restock
      vends = 0;
      for (int k = 0; k < 8; k++) begin
         step(3'b001, 2'd0, 1'b0, 1'b0, 1'b0);
         step(3'b100, 2'd0, 1'b0, 1'b0, 1'b0);
         step(3'b000, 2'd2, 1'b1, 1'b0, 1'b0);
         if (vif.vend && vif.vend_item == 2'd2) vends++;
         step(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
      end
      chk("item2_vends", 32'(vends), 32'd8);
      chk("item2_sold_out", 32'(vif.sold_out), 32'h4);
      step(3'b001, 2'd0, 1'b0, 1'b0, 1'b0);
      step(3'b100, 2'd0, 1'b0, 1'b0, 1'b0);
      step(3'b000, 2'd2, 1'b1, 1'b0, 1'b0);
      chk("soldout_buy", 32'({vif.vend, vif.busy, vif.credit}), 32'({1'b0, 1'b0, 8'd6}));
      step(3'b000, 2'd0, 1'b0, 1'b0, 1'b1);
      chk("restock", 32'({vif.sold_out, vif.credit}), 32'({4'h0, 8'd6}));
      step(3'b000, 2'd0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 10 && vif.busy; k++) step(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("drain6", 32'({vif.busy, vif.credit}), 32'({1'b0, 8'd0}));

      // exhaust item 1, then reset in the middle of a payout
      for (int k = 0; k < 8; k++) begin
         step(3'b001, 2'd0, 1'b0, 1'b0, 1'b0);
         step(3'b000, 2'd1, 1'b1, 1'b0, 1'b0);
         step(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
      end
      chk("item1_sold_out", 32'(vif.sold_out), 32'h2);
      step(3'b010, 2'd0, 1'b0, 1'b0, 1'b0);
      step(3'b010, 2'd0, 1'b0, 1'b0, 1'b0);
      step(3'b000, 2'd0, 1'b0, 1'b1, 1'b0);
      chk("change4_start", 32'({vif.chg_d, vif.busy, vif.credit}), 32'({1'b1, 1'b1, 8'd4}));
      #2;
      rs = 1'b0;
      #1;
      chk("async_reset", 32'({vif.chg_d, vif.chg_n, vif.busy, vif.vend, vif.credit}),
          32'({4'b0000, 8'd0}));
      @(negedge clk);
      rs = 1'b1;
      step(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("post_reset", 32'({vif.sold_out, vif.busy, vif.credit}), 32'({4'h0, 1'b0, 8'd0}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
